// File: rtl/tool_gry_ptr_rx.sv
// Receive side of a Gray-coded pointer crossing: synchronizes, decodes to binary,
// tracks increments not yet acknowledged, and flags illegal multi-bit Gray steps.
module tool_gry_ptr_rx #(
  parameter int DATA_WIDTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_gry,
  input  logic                  i_ack,
  input  logic                  i_clr_err,
  output logic [DATA_WIDTH-1:0] o_bin,
  output logic [DATA_WIDTH-1:0] o_dlt,
  output logic                  o_vld,
  output logic                  o_err
);

  localparam int PRIME_EDGES = SYNC_STAGES + 1;
  localparam int CW          = $clog2(PRIME_EDGES + 1);

  typedef logic [DATA_WIDTH-1:0] ptr_t;

  ptr_t          sync_q [SYNC_STAGES];
  ptr_t          s_gry;
  ptr_t          p_gry_q;
  ptr_t          gry_diff;
  ptr_t          bin_q, bin_d;
  ptr_t          ack_q, ack_d;
  logic          err_q, err_d;
  logic [CW-1:0] prime_cnt_q, prime_cnt_d;
  logic          priming;
  logic          illegal;

  function automatic ptr_t gray_to_bin(input ptr_t g);
    ptr_t b;
    b[DATA_WIDTH-1] = g[DATA_WIDTH-1];
    for (int k = DATA_WIDTH - 2; k >= 0; k--) begin
      b[k] = b[k+1] ^ g[k];
    end
    return b;
  endfunction

  assign s_gry    = sync_q[SYNC_STAGES-1];
  assign gry_diff = s_gry ^ p_gry_q;
  // Two or more bits changed exactly when clearing the lowest set bit leaves bits behind.
  assign illegal  = |(gry_diff & (gry_diff - ptr_t'(1)));
  assign priming  = (prime_cnt_q != CW'(PRIME_EDGES));

  // NOTE: every variable gets a default before any condition, so no latch is inferred.
  always_comb begin
    bin_d       = gray_to_bin(s_gry);
    prime_cnt_d = prime_cnt_q;
    ack_d       = ack_q;
    err_d       = err_q;

    if (priming) begin
      prime_cnt_d = prime_cnt_q + CW'(1);
      ack_d       = bin_d;
    end else if (i_ack && o_vld) begin
      // The pre-edge o_bin is taken, so an increment arriving on this edge stays pending.
      ack_d = bin_q;
    end

    if (i_clr_err) begin
      err_d = 1'b0;
    end
    if (!priming && illegal) begin
      err_d = 1'b1;
    end
  end

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
  // which is what makes the synchronizer chain shift by exactly one stage per edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      // NOTE: the stage array is a handful of flops, not a RAM, so it is reset
      // like any other register.
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      p_gry_q     <= '0;
      bin_q       <= '0;
      ack_q       <= '0;
      err_q       <= 1'b0;
      prime_cnt_q <= '0;
    end else begin
      sync_q[0] <= i_gry;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      p_gry_q     <= s_gry;
      bin_q       <= bin_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      prime_cnt_q <= prime_cnt_d;
    end
  end

  assign o_bin = bin_q;
  assign o_dlt = bin_q - ack_q;
  assign o_vld = |o_dlt;
  assign o_err = err_q;

endmodule

// File: tb/tb_tool_gry_ptr_rx.sv
// Directed bench for tool_gry_ptr_rx: a queue holds the binary value expected for
// each driven Gray code and is compared once the 3-cycle pointer latency has elapsed.
module tb_tool_gry_ptr_rx;

  localparam int W   = 4;
  localparam int LAT = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ack;
  logic         clr;
  logic [W-1:0] gry;
  logic [W-1:0] bin;
  logic [W-1:0] dlt;
  logic         vld;
  logic         err;

  int           n_checks = 0;
  int           n_pass   = 0;
  int           n_fail   = 0;
  logic [W-1:0] sb [$];

  always #5 clk = ~clk;

  tool_gry_ptr_rx #(.DATA_WIDTH(W), .SYNC_STAGES(2)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_gry    (gry),
    .i_ack    (ack),
    .i_clr_err(clr),
    .o_bin    (bin),
    .o_dlt    (dlt),
    .o_vld    (vld),
    .o_err    (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] gray_of(input int n);
    logic [W-1:0] b;
    b = n[W-1:0];
    return b ^ (b >> 1);
  endfunction

  // Drive one Gray code for one cycle; compare o_bin against the entry due now.
  task automatic step_raw(input logic [W-1:0] g, input logic [W-1:0] exp_bin,
                          input logic a, input logic c);
    logic [W-1:0] e;
    gry = g;
    ack = a;
    clr = c;
    sb.push_back(exp_bin);
    tick();
    ack = 1'b0;
    clr = 1'b0;
    if (sb.size() >= LAT) begin
      e = sb.pop_front();
      check("o_bin", 32'(bin), 32'(e));
    end
  endtask

  task automatic step(input int n);
    step_raw(gray_of(n), n[W-1:0], 1'b0, 1'b0);
  endtask

  task automatic step_ack(input int n);
    step_raw(gray_of(n), n[W-1:0], 1'b1, 1'b0);
  endtask

  task automatic do_reset(input logic [W-1:0] g);
    rst_n = 1'b0;
    gry   = g;
    ack   = 1'b0;
    clr   = 1'b0;
    tick();
    tick();
    check("rst o_bin", 32'(bin), 0);
    check("rst o_dlt", 32'(dlt), 0);
    check("rst o_vld", 32'(vld), 0);
    check("rst o_err", 32'(err), 0);
    rst_n = 1'b1;
    sb.delete();
  endtask

  task automatic check_state(input string tag, input int exp_dlt, input int exp_vld,
                             input int exp_err);
    check({tag, " o_dlt"}, 32'(dlt), exp_dlt);
    check({tag, " o_vld"}, 32'(vld), exp_vld);
    check({tag, " o_err"}, 32'(err), exp_err);
  endtask

  initial begin
    rst_n = 1'b0;
    gry   = '0;
    ack   = 1'b0;
    clr   = 1'b0;

    // Reset with a nonzero pointer held, then prime onto it.
    do_reset(4'b0110);
    repeat (3) step_raw(4'b0110, 4'd4, 1'b0, 1'b0);
    check_state("prime", 0, 0, 0);

    // Count 1..9 without acknowledging.
    do_reset(4'b0000);
    repeat (3) step(0);
    check_state("zero", 0, 0, 0);
    for (int n = 1; n <= 9; n++) step(n);
    repeat (2) step(9);
    check_state("count", 9, 1, 0);

    // Wrap-around delta.
    for (int n = 10; n <= 14; n++) step(n);
    repeat (2) step(14);
    step_ack(14);
    check_state("ack14", 0, 0, 0);
    step(15);
    step(0);
    step(1);
    repeat (2) step(1);
    check_state("wrap", 3, 1, 0);
    step_ack(1);
    check_state("ackwrap", 0, 0, 0);

    // Ack with nothing pending, then ack racing an increment.
    step_ack(1);
    check_state("idle ack", 0, 0, 0);
    repeat (3) step(2);
    check_state("one pend", 1, 1, 0);
    step_ack(2);
    check_state("ack2", 0, 0, 0);
    for (int n = 3; n <= 6; n++) step(n);
    step(6);
    check_state("pre race", 3, 1, 0);
    step_ack(6);
    check_state("race", 1, 1, 0);
    step_ack(6);
    check_state("post race", 0, 0, 0);

    // Illegal transition, sticky error, set-over-clear, clean clear.
    for (int n = 7; n <= 15; n++) step(n);
    repeat (3) step(0);
    check("pre jump o_err", 32'(err), 0);
    step_raw(4'b0011, 4'd2, 1'b0, 1'b0);
    check("jump e+1 o_err", 32'(err), 0);
    step_raw(4'b0011, 4'd2, 1'b0, 1'b0);
    check("jump e+2 o_err", 32'(err), 0);
    step_raw(4'b0011, 4'd2, 1'b0, 1'b0);
    check("jump e+3 o_err", 32'(err), 1);
    step(3);
    step(4);
    step(4);
    check("sticky o_err", 32'(err), 1);
    step_raw(4'b0001, 4'd1, 1'b0, 1'b0);
    step_raw(4'b0001, 4'd1, 1'b0, 1'b0);
    step_raw(4'b0001, 4'd1, 1'b0, 1'b1);
    check("set wins o_err", 32'(err), 1);
    step_raw(4'b0001, 4'd1, 1'b0, 1'b1);
    check("clear o_err", 32'(err), 0);
    step_raw(4'b0001, 4'd1, 1'b0, 1'b0);
    check("cleared o_err", 32'(err), 0);

    // Build up delta 7 with the error set, then reset mid-operation.
    repeat (3) step_raw(4'b0010, 4'd3, 1'b0, 1'b0);
    check("jump2 o_err", 32'(err), 1);
    step_raw(4'b0010, 4'd3, 1'b1, 1'b0);
    for (int n = 4; n <= 10; n++) step(n);
    repeat (2) step(10);
    check_state("busy", 7, 1, 1);
    do_reset(gray_of(10));
    repeat (3) step(10);
    check_state("reprime", 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
